// File: rtl/cla_addsub_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared types and constants for the sequential carry-lookahead
//                adder/subtractor (slice width, FSM state type, result flags).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

  // Bits processed per clock by one lookahead slice.
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/cla_addsub_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_addsub_seq_if
//  Description : Operand/result handshake bundle for cla_addsub_seq.
//  Ports       : request side  - in_valid, in_ready, a, b, mode, c_in
//                response side - out_valid, out_ready, sum, c_out, ovf,
//                                zero, neg
//                master = operand producer / result consumer
//                slave  = the adder/subtractor
//  Revision    : 1.0 - initial release
// ============================================================================
interface cla_addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, mode, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, mode, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero, neg
  );
endinterface
`default_nettype wire

// File: rtl/cla_addsub_seq_slice4.sv
`default_nettype none
// ============================================================================
//  Module      : cla_slice4
//  Description : Combinational 4-bit carry-lookahead slice. All internal
//                carries are formed directly from generate/propagate terms
//                and the slice carry-in (no ripple inside the slice).
//  Ports       : a[3:0], b[3:0], cin -> sum[3:0],
//                c3 (carry into bit 3), c4 (carry out of bit 3)
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_slice4 (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  input  wire logic       cin,
  output logic      [3:0] sum,
  output logic            c3,
  output logic            c4
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic       w_c1;
  logic       w_c2;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c1 = w_g[0] | (w_p[0] & cin);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ {c3, w_c2, w_c1, cin};
endmodule
`default_nettype wire

// File: rtl/cla_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cla_addsub_seq
//  Description : Multi-cycle WIDTH-bit adder/subtractor. One 4-bit lookahead
//                slice is evaluated per clock, least-significant first, with
//                the inter-slice carry held in a register. Results are
//                presented with carry, signed-overflow, zero and negative
//                flags over a valid/ready handshake.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - cla_addsub_seq_if.slave (operands in, result out)
//  Parameters  : WIDTH  - operand width, positive multiple of 4
//  Macros      : CLA_ADDSUB_SATURATE_EN - clamp sum on signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_addsub_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input wire logic        clk,
  input wire logic        rst_n,
  cla_addsub_seq_if.slave bus
);
  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SLICES - 1);
  localparam logic [1:0]       c_ST_IDLE  = IDLE;
  localparam logic [1:0]       c_ST_RUN   = RUN;
  localparam logic [1:0]       c_ST_DONE  = DONE;

  generate
    if ((WIDTH <= 0) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
      $error("cla_addsub_seq: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_nb;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  flags_t           r_flags;

  logic [31:0]      w_base;
  logic [3:0]       w_a_slice;
  logic [3:0]       w_b_slice;
  logic [3:0]       w_slice_sum;
  logic             w_c3;
  logic             w_c4;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_next_sum;
  logic [WIDTH-1:0] w_final_sum;

  assign w_base    = 32'(r_idx) * 32'(SLICE_W);
  assign w_a_slice = r_a[w_base +: SLICE_W];
  assign w_b_slice = r_nb[w_base +: SLICE_W];
  assign w_last    = (r_idx == c_LAST_IDX);
  // On the top slice c3/c4 are the carries into and out of the MSB.
  assign w_ovf     = w_c3 ^ w_c4;

  cla_slice4 u_slice (
    .a   (w_a_slice),
    .b   (w_b_slice),
    .cin (r_carry),
    .sum (w_slice_sum),
    .c3  (w_c3),
    .c4  (w_c4)
  );

  // Only the active slice is replaced; pending slices keep their old bits.
  always_comb begin
    w_next_sum                    = r_sum;
    w_next_sum[w_base +: SLICE_W] = w_slice_sum;
  end

`ifdef CLA_ADDSUB_SATURATE_EN
  // Overflow is only possible when both effective operands share a sign,
  // so the sign of A tells the overflow direction.
  always_comb begin
    w_final_sum = w_next_sum;
    if (w_ovf) begin
      w_final_sum = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_final_sum = w_next_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_nb    <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_nb    <= bus.b ^ {WIDTH{bus.mode}};
            // Subtract is a + ~b + 1; a set c_in turns that into a borrow.
            r_carry <= bus.c_in ^ bus.mode;
            r_idx   <= '0;
            r_state <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          r_carry <= w_c4;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_sum         <= w_final_sum;
            r_flags.c_out <= w_c4;
            r_flags.ovf   <= w_ovf;
            r_flags.zero  <= (w_final_sum == '0);
            r_flags.neg   <= w_final_sum[WIDTH-1];
            r_state       <= c_ST_DONE;
          end else begin
            r_sum <= w_next_sum;
          end
        end
        c_ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == c_ST_IDLE);
  assign bus.out_valid = (r_state == c_ST_DONE);
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_flags.c_out;
  assign bus.ovf       = r_flags.ovf;
  assign bus.zero      = r_flags.zero;
  assign bus.neg       = r_flags.neg;
endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_addsub_seq
//  Description : Self-checking bench for cla_addsub_seq (WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_addsub_seq;
  localparam int W      = 16;
  localparam int SLICES = W / 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [3:0]   flags;  // {c_out, ovf, zero, neg}
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cla_addsub_seq_if #(.WIDTH(W)) bus ();

  cla_addsub_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  logic prev_ov  = 1'b0;
  exp_t q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on the whole word.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic mode, input logic cin);
    logic [W:0]   full;
    logic [W-1:0] nb;
    logic [W-1:0] s;
    logic         c, o;
    nb   = mode ? ~b : b;
    full = {1'b0, a} + {1'b0, nb} + {{W{1'b0}}, (cin ^ mode)};
    s    = full[W-1:0];
    c    = full[W];
    o    = (a[W-1] == nb[W-1]) && (s[W-1] != a[W-1]);
`ifdef CLA_ADDSUB_SATURATE_EN
    if (o) s = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    model.sum   = s;
    model.flags = {c, o, (s == '0), s[W-1]};
  endfunction

  // Scoreboard: push on accept, compare every cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.mode, bus.c_in));
        acc_cyc = cyc + 1;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          check("cmp_sum", 32'(bus.sum), 32'(q[0].sum));
          check("cmp_flags", 32'({bus.c_out, bus.ovf, bus.zero, bus.neg}), 32'(q[0].flags));
          check("cmp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        if (!prev_ov) check("latency", 32'(cyc - acc_cyc), 32'(SLICES));
        if (bus.out_ready && q.size() > 0) void'(q.pop_front());
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic wait_accept();
    int k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 50) begin @(negedge clk); k++; end
    if (!bus.out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after handshake.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic c,
                        input logic [W-1:0] es, input logic [3:0] ef);
    exp_t mdl;
    mdl = model(a, b, m, c);
    check({nm, "_model_sum"}, 32'(mdl.sum), 32'(es));
    check({nm, "_model_flags"}, 32'(mdl.flags), 32'(ef));
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.mode = m; bus.c_in = c;
    bus.out_ready = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    wait_valid();
    check({nm, "_sum"}, 32'(bus.sum), 32'(es));
    check({nm, "_flags"}, 32'({bus.c_out, bus.ovf, bus.zero, bus.neg}), 32'(ef));
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.c_in = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_flags", 32'({bus.c_out, bus.ovf, bus.zero, bus.neg}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 4'b0000);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 4'b0001);
`ifdef CLA_ADDSUB_SATURATE_EN
    run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 4'b0100);
    run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 4'b1101);
`else
    run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101);
    run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0001, 4'b1100);
`endif
    run_op("ripple_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1010);
    run_op("sub_bin", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 4'b1000);

    // Back-pressure: result held while a second request waits.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 16'h0100; bus.b = 16'h0023; bus.mode = 1'b0; bus.c_in = 1'b0;
    wait_accept();
    bus.a = 16'h0003; bus.b = 16'h0004;
    wait_valid();
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("hold_sum", 32'(bus.sum), 32'h0123);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_valid();
    check("second_op_sum", 32'(bus.sum), 32'h0007);
    @(posedge clk); #1;

    // Reset during the second RUN cycle.
    bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.mode = 1'b0; bus.c_in = 1'b0;
    wait_accept();
    bus.in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_flags", 32'({bus.c_out, bus.ovf, bus.zero, bus.neg}), 32'd0);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 4'b0000);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
